// File: rtl/conv_sched.sv
// conv_sched: sequences co/pix/ci buffer reads and accumulator strobes for one conv layer.
// Optional CONV_SCHED_PERF_CNT_EN adds busy/stall performance counters.
module conv_sched #(
    parameter logic [2:0] STATE_CONV          = 3'd2,
    parameter int         MULT_PIPELINE_STAGE = 2,
    parameter int         PIX_WIDTH           = 12,
    parameter int         GRP_WIDTH           = 6,
    parameter int         ADDR_WIDTH          = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            current_state,
    output logic                  state_end,
    input  logic [PIX_WIDTH-1:0]  cfg_pix_num,
    input  logic [GRP_WIDTH-1:0]  cfg_ci_grp,
    input  logic [GRP_WIDTH-1:0]  cfg_co_grp,
    input  logic [3:0]            cfg_scale,
    input  logic                  out_ready,
    output logic                  fmap_rd_en,
    output logic [ADDR_WIDTH-1:0] fmap_rd_addr,
    output logic                  wt_rd_en,
    output logic [ADDR_WIDTH-1:0] wt_rd_addr,
    output logic                  adder_rst,
    output logic                  acc_valid,
    output logic [3:0]            scale_in,
    output logic [31:0]           perf_busy_cnt,
    output logic [31:0]           perf_stall_cnt
);
    localparam int L = 1 + MULT_PIPELINE_STAGE;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    state_t                state;
    logic                  armed;
    logic [PIX_WIDTH-1:0]  pix_num, pix;
    logic [GRP_WIDTH-1:0]  ci_grp, co_grp, ci, co;
    logic [ADDR_WIDTH-1:0] fmap_addr, wt_base;
    logic [L-1:0]          first_pipe;
    logic [L:0]            last_pipe;
    logic                  in_conv, issue, last_ci, last_pix, last_co;
    assign in_conv      = current_state == STATE_CONV;
    // a pixel may only start while downstream can take its result
    assign issue        = state == RUN && (ci != '0 || out_ready);
    assign last_ci      = ci == ci_grp - GRP_WIDTH'(1);
    assign last_pix     = pix == pix_num - PIX_WIDTH'(1);
    assign last_co      = co == co_grp - GRP_WIDTH'(1);
    assign fmap_rd_en   = issue;
    assign wt_rd_en     = issue;
    assign fmap_rd_addr = fmap_addr;
    assign wt_rd_addr   = wt_base + ADDR_WIDTH'(ci);
    assign adder_rst    = first_pipe[L-1];
    assign acc_valid    = last_pipe[L];
    assign state_end    = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b1;
            pix_num    <= '0;
            ci_grp     <= '0;
            co_grp     <= '0;
            scale_in   <= '0;
            pix        <= '0;
            ci         <= '0;
            co         <= '0;
            fmap_addr  <= '0;
            wt_base    <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            if (!in_conv) armed <= 1'b1;
            first_pipe <= (first_pipe << 1) | L'(issue && ci == '0);
            last_pipe  <= (last_pipe << 1) | (L+1)'(issue && last_ci);
            case (state)
                IDLE: if (in_conv && armed) begin
                    state <= LOAD;
                    armed <= 1'b0;
                end
                LOAD: begin
                    pix_num   <= cfg_pix_num;
                    ci_grp    <= cfg_ci_grp;
                    co_grp    <= cfg_co_grp;
                    scale_in  <= cfg_scale;
                    pix       <= '0;
                    ci        <= '0;
                    co        <= '0;
                    fmap_addr <= '0;
                    wt_base   <= '0;
                    state     <= !in_conv ? IDLE :
                                 (cfg_pix_num == '0 || cfg_ci_grp == '0 || cfg_co_grp == '0) ? DONE : RUN;
                end
                RUN: if (!in_conv) begin
                    state      <= IDLE;
                    first_pipe <= '0;
                    last_pipe  <= '0;
                end else if (issue) begin
                    ci <= last_ci ? '0 : ci + GRP_WIDTH'(1);
                    if (last_ci) begin
                        pix       <= last_pix ? '0 : pix + PIX_WIDTH'(1);
                        fmap_addr <= last_pix ? '0 : fmap_addr + ADDR_WIDTH'(1);
                        if (last_pix) begin
                            co      <= co + GRP_WIDTH'(1);
                            wt_base <= wt_base + ADDR_WIDTH'(ci_grp);
                            if (last_co) state <= DRAIN;
                        end
                    end else begin
                        fmap_addr <= fmap_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: if (!in_conv) begin
                    state      <= IDLE;
                    first_pipe <= '0;
                    last_pipe  <= '0;
                end else if (~|last_pipe[L-1:0]) begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef CONV_SCHED_PERF_CNT_EN
    logic [31:0] busy_cnt, stall_cnt;
    always_ff @(posedge clk) begin
        if (rst || state == LOAD) begin
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if ((state == RUN || state == DRAIN) && !(&busy_cnt)) busy_cnt <= busy_cnt + 32'd1;
            if (state == RUN && !issue && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
        end
    end
    assign perf_busy_cnt  = busy_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_busy_cnt  = '0;
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed layers with a read/strobe scoreboard for conv_sched.
module tb_conv_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  current_state;
    logic        state_end;
    logic [11:0] cfg_pix_num;
    logic [5:0]  cfg_ci_grp, cfg_co_grp;
    logic [3:0]  cfg_scale, scale_in;
    logic        out_ready, fmap_rd_en, wt_rd_en, adder_rst, acc_valid;
    logic [13:0] fmap_rd_addr, wt_rd_addr;
    logic [31:0] perf_busy_cnt, perf_stall_cnt;
`ifdef CONV_SCHED_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    conv_sched dut (
        .clk(clk), .rst(rst), .current_state(current_state), .state_end(state_end),
        .cfg_pix_num(cfg_pix_num), .cfg_ci_grp(cfg_ci_grp), .cfg_co_grp(cfg_co_grp),
        .cfg_scale(cfg_scale), .out_ready(out_ready),
        .fmap_rd_en(fmap_rd_en), .fmap_rd_addr(fmap_rd_addr),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
        .adder_rst(adder_rst), .acc_valid(acc_valid), .scale_in(scale_in),
        .perf_busy_cnt(perf_busy_cnt), .perf_stall_cnt(perf_stall_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {int f; int w; bit first; bit last;} rd_t;
    rd_t exp_q[$];
    int  rst_q[$];
    int  val_q[$];
    rd_t e;
    int  checks = 0, errors = 0, cyc = 0, issue_cnt = 0, n_rst = 0, n_val = 0, se_cnt = 0, e0 = 0;
    always @(posedge clk) cyc++;
    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // scoreboard: each read pops its expected addresses and schedules the strobes it implies
    always @(negedge clk) begin
        if (rst_q.size() != 0 && rst_q[0] < cyc) chk("adder_rst_missed", cyc, rst_q.pop_front());
        if (val_q.size() != 0 && val_q[0] < cyc) chk("acc_valid_missed", cyc, val_q.pop_front());
        if (adder_rst) begin
            n_rst++;
            if (rst_q.size() == 0) chk("adder_rst_unexpected", 1, 0);
            else chk("adder_rst_cycle", cyc, rst_q.pop_front());
        end
        if (acc_valid) begin
            n_val++;
            if (val_q.size() == 0) chk("acc_valid_unexpected", 1, 0);
            else chk("acc_valid_cycle", cyc, val_q.pop_front());
        end
        if (state_end) se_cnt++;
        if (fmap_rd_en || wt_rd_en) chk("rd_en_pair", wt_rd_en, fmap_rd_en);
        if (fmap_rd_en) begin
            issue_cnt++;
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("fmap_rd_addr", fmap_rd_addr, e.f);
                chk("wt_rd_addr", wt_rd_addr, e.w);
                if (e.first) rst_q.push_back(cyc + 3);
                if (e.last) val_q.push_back(cyc + 4);
            end
        end
    end
    task automatic start_layer(input int p, input int c, input int o, input int s);
        @(posedge clk); #1;
        cfg_pix_num = 12'(p);
        cfg_ci_grp  = 6'(c);
        cfg_co_grp  = 6'(o);
        cfg_scale   = 4'(s);
        for (int oo = 0; oo < o; oo++)
            for (int pp = 0; pp < p; pp++)
                for (int cc = 0; cc < c; cc++)
                    exp_q.push_back('{pp * c + cc, oo * c + cc, cc == 0, cc == c - 1});
        issue_cnt = 0;
        n_rst = 0;
        n_val = 0;
        current_state = 3'd2;
        e0 = cyc;
    endtask
    task automatic finish_layer(input int exp_dt, input string tag);
        int seen = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (state_end) begin
                seen = cyc;
                break;
            end
        end
        chk({tag, "_state_end_cycle"}, seen - e0, exp_dt);
        @(negedge clk);
        chk({tag, "_state_end_pulse"}, state_end, 0);
        chk({tag, "_rd_left"}, exp_q.size(), 0);
        chk({tag, "_rst_left"}, rst_q.size(), 0);
        chk({tag, "_val_left"}, val_q.size(), 0);
        @(posedge clk); #1;
        current_state = 3'd0;
    endtask
    task automatic wait_issues(input int n);
        for (int i = 0; i < 100 && issue_cnt < n; i++) begin
            @(negedge clk); #1;
        end
        chk("wait_issues", issue_cnt >= n, 1);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int se0, i0, v0, r0;
        rst = 1'b1;
        current_state = 3'd0;
        out_ready = 1'b1;
        cfg_pix_num = '0;
        cfg_ci_grp = '0;
        cfg_co_grp = '0;
        cfg_scale = 4'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_en", fmap_rd_en | wt_rd_en, 0);
        chk("reset_addr", {fmap_rd_addr, wt_rd_addr}, 0);
        chk("reset_strobes", {adder_rst, acc_valid, state_end}, 0);
        chk("reset_scale", scale_in, 0);
        chk("reset_perf", perf_busy_cnt | perf_stall_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // basic layer
        se0 = se_cnt;
        start_layer(4, 3, 2, 5);
        finish_layer(30, "basic");
        chk("basic_issues", issue_cnt, 24);
        chk("basic_adder_rst", n_rst, 8);
        chk("basic_acc_valid", n_val, 8);
        chk("basic_scale", scale_in, 5);
        chk("basic_busy", perf_busy_cnt, PERF ? 28 : 0);
        chk("basic_stall", perf_stall_cnt, 0);
        chk("basic_state_end_count", se_cnt - se0, 1);
        // single input-channel group
        se0 = se_cnt;
        start_layer(3, 1, 1, 9);
        finish_layer(9, "ci1");
        chk("ci1_adder_rst", n_rst, 3);
        chk("ci1_acc_valid", n_val, 3);
        chk("ci1_state_end_count", se_cnt - se0, 1);
        chk("ci1_scale", scale_in, 9);
        // backpressure before pixel 2
        start_layer(4, 2, 1, 3);
        wait_issues(4);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_stalled_issues", issue_cnt, 4);
        out_ready = 1'b1;
        finish_layer(19, "bp");
        chk("bp_issues", issue_cnt, 8);
        chk("bp_acc_valid", n_val, 4);
        chk("bp_stall", perf_stall_cnt, PERF ? 5 : 0);
        chk("bp_busy", perf_busy_cnt, PERF ? 17 : 0);
        // zero configuration
        start_layer(0, 3, 2, 1);
        finish_layer(2, "zero");
        chk("zero_issues", issue_cnt, 0);
        chk("zero_strobes", n_rst + n_val, 0);
        // abort mid-RUN
        start_layer(4, 3, 2, 5);
        wait_issues(5);
        @(posedge clk); #1;
        current_state = 3'd0;
        @(posedge clk); #1;
        exp_q.delete();
        rst_q.delete();
        val_q.delete();
        se0 = se_cnt;
        i0 = issue_cnt;
        v0 = n_val;
        r0 = n_rst;
        repeat (10) @(negedge clk);
        chk("abort_no_rd", issue_cnt, i0);
        chk("abort_no_acc_valid", n_val, v0);
        chk("abort_no_adder_rst", n_rst, r0);
        chk("abort_no_state_end", se_cnt, se0);
        start_layer(4, 3, 2, 6);
        finish_layer(30, "restart");
        chk("restart_acc_valid", n_val, 8);
        chk("restart_scale", scale_in, 6);
        // reset mid-RUN
        start_layer(4, 3, 2, 7);
        wait_issues(6);
        @(posedge clk); #1;
        rst = 1'b1;
        current_state = 3'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        rst_q.delete();
        val_q.delete();
        i0 = issue_cnt;
        v0 = n_val;
        @(negedge clk);
        chk("rstrun_rd_en", fmap_rd_en | wt_rd_en, 0);
        chk("rstrun_addr", {fmap_rd_addr, wt_rd_addr}, 0);
        chk("rstrun_strobes", {adder_rst, acc_valid, state_end}, 0);
        chk("rstrun_scale", scale_in, 0);
        chk("rstrun_perf", perf_busy_cnt | perf_stall_cnt, 0);
        repeat (6) @(negedge clk);
        chk("rstrun_idle_rd", issue_cnt, i0);
        chk("rstrun_idle_val", n_val, v0);
        start_layer(2, 2, 1, 4);
        finish_layer(10, "after_rst");
        chk("after_rst_acc_valid", n_val, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
